yutorina_mem_stage: RTL and testbench
=====================================

// Module: yutorina_mem_stage
// PURPOSE
//  MEM pipeline stage, directly downstream of the EX stage register. Executes loads and stores
//  against the shared bus via a req/ack master FSM. Raises misalignment exceptions, stalls the
//  pipeline while an access is outstanding, and registers results toward WB.
//  Non-memory instructions pass through with 1-cycle latency.
// PARAMETERS
//  WORD_W    32  data word width; bus data width
//  ADDR_W    30  bus word-address width (byte address = {bus_addr, 2'b00})
//  BE_W       4  byte enables, WORD_W/8
// PORTS
//  clk           in   1      clock
//  rst           in   1      reset: synchronous, active-high
//  stall         in   1      downstream hold: output regs keep value
//  flush         in   1      discard the instruction currently in MEM
//  ex_en_        in   1      EX register valid (active-low)
//  ex_w_addr     in   GPR    destination register
//  ex_w_data     in   WORD   store data
//  ex_gpr_we_    in   1      GPR write enable (active-low)
//  ex_exp_code   in   EXP    exception carried from earlier stages
//  ex_mem_op     in   MEMOP  MEM_NONE/LDW/STW/LDB/STB
//  ex_ctrl_op    in   CTRL   control op; passed through
//  ex_out        in   WORD   ALU result; byte address for memory ops
//  mem_en_, mem_w_addr, mem_gpr_we_, mem_exp_code, mem_ctrl_op, mem_out
//                out  as ex_*  registered results to WB
//  busy          out  1      combinational; pipeline controller stalls IF/ID/EX while high
//  bus_req_      out  1      registered bus request (active-low)
//  bus_rw        out  1      BUS_READ=1, BUS_WRITE=0
//  bus_addr      out  ADDR_W word address
//  bus_be        out  BE_W   byte enables
//  bus_wr_data   out  WORD   write data
//  bus_rd_data   in   WORD   read data; valid with bus_ack_
//  bus_ack_      in   1      transfer complete (active-low)
// BEHAVIOUR
//  - Reset: all outputs reset synchronously, state=IDLE.
//    mem_en_/mem_gpr_we_/bus_req_ = DISABLE_; mem_exp_code = EXP_NONE; mem_ctrl_op = CTRL_NONE.
//    All data/addr/be/rw outputs = 0. Reset mid-access drops bus_req_ at the next edge.
//  - Access = ex_en_ enabled & ex_mem_op != MEM_NONE & ex_exp_code == EXP_NONE & !flush.
//  - Misaligned = LDW/STW with ex_out[1:0] != 0. No bus access.
//    Result: mem_exp_code = EXP_MISS_ALIGN, mem_gpr_we_ disabled, 1-cycle pass.
//  - FSM states IDLE, REQ, DONE:
//    IDLE -> REQ on aligned access. At that edge latch bus_addr = ex_out[31:2], rw, be, wr_data.
//      Assert bus_req_. Drive mem_en_ disabled (bubble).
//    REQ: hold all bus signals until bus_ack_. On ack: deassert bus_req_ and latch rd_data.
//      Then go to IDLE and write the result regs if !stall; otherwise go to DONE.
//    DONE: wait for !stall, write result regs, then IDLE.
//  - busy = (IDLE & aligned access) | REQ | DONE.
//    EX register is frozen by the controller, so inputs are stable throughout.
//  - Minimum load/store latency: 2 cycles (issue edge + ack in first REQ cycle).
//  - Byte lanes, little-endian, k = ex_out[1:0]:
//    LDB/STB: be = 1<<k. STB replicates the byte to all 4 lanes.
//    LDB result = sign-extended rd_data[8k+:8]. Word ops: be = 4'b1111.
//  - Result: mem_out = load data for loads, ex_out otherwise.
//    Stores force mem_gpr_we_ disabled. Other fields copy the latched ex_* values.
//  - Non-access valid instruction in IDLE, !stall: register ex_* fields, 1-cycle latency.
//  - ex_en_ disabled: mem_en_ and mem_gpr_we_ disabled; other output regs hold.
//  - stall in IDLE: outputs hold; no new access issues.
//  - flush in IDLE: instruction dropped, mem_en_ disabled.
//  - flush in REQ/DONE: bus transaction still completes (stores are committed).
//    The result is discarded: mem_en_ disabled on completion.
//  - bus_ack_ seen outside REQ is ignored.
// STRUCTURE
//  - isa.h supplies MEM_* opcodes. exp.h gains EXP_MISS_ALIGN.
//  - New bus.h supplies BUS_READ/BUS_WRITE, ByteEnBus, WordAddrBus, and the MEM_ST_IDLE/REQ/DONE encodings.
//  - Sub-module yutorina_mem_ctrl: FSM, bus registers, alignment check, byte extract/replicate, busy.
//  - Top level: pipeline output registers, stall/flush gating.
// TESTING
//  1. ALU op, ex_out=32'h1234, we_ enabled -> next cycle mem_out=32'h1234, mem_en_ enabled, busy=0.
//  2. LDW addr 32'h100, ack on 1st REQ cycle, rd_data=32'hDEADBEEF.
//     -> bus_addr=30'h40, be=4'hF, busy high 2 cycles, mem_out=32'hDEADBEEF.
//  3. STB addr 32'h103, data 32'h5A, ack after 3 wait cycles.
//     -> be=4'b1000, wr_data=32'h5A5A5A5A, bus signals stable, mem_gpr_we_ disabled.
//  4. LDB addr 32'h102, rd_data=32'h00800000 -> mem_out=32'hFFFFFF80.
//  5. LDW addr 32'h102 -> no bus_req_, mem_exp_code=EXP_MISS_ALIGN, mem_gpr_we_ disabled.
//  6. Stall during REQ ack -> DONE holds result until stall drops.
//     Flush in REQ -> ack accepted, mem_en_ disabled.
//     rst in REQ -> bus_req_ disabled next edge.

Source files
------------

// File: rtl/yutorina_mem_stage_pkg.sv
// Shared types and constants for the MEM stage: memory/exception/control opcodes,
// bus direction, FSM state encoding and the byte-lane extraction helper.
package yutorina_mem_stage_pkg;

   localparam int WORD_W     = 32;
   localparam int ADDR_W     = 30;
   localparam int BE_W       = 4;
   localparam int GPR_ADDR_W = 5;

   localparam logic ENABLE_   = 1'b0;
   localparam logic DISABLE_  = 1'b1;
   localparam logic BUS_READ  = 1'b1;
   localparam logic BUS_WRITE = 1'b0;

   typedef enum logic [2:0] {
      MEM_NONE = 3'd0,
      MEM_LDW  = 3'd1,
      MEM_STW  = 3'd2,
      MEM_LDB  = 3'd3,
      MEM_STB  = 3'd4
   } mem_op_t;

   typedef enum logic [2:0] {
      EXP_NONE       = 3'd0,
      EXP_EXT_INT    = 3'd1,
      EXP_UNDEF_INSN = 3'd2,
      EXP_OVERFLOW   = 3'd3,
      EXP_MISS_ALIGN = 3'd4
   } exp_code_t;

   typedef enum logic [1:0] {
      CTRL_NONE = 2'd0,
      CTRL_WRCR = 2'd1,
      CTRL_EXRT = 2'd2
   } ctrl_op_t;

   typedef enum logic [1:0] {
      MEM_ST_IDLE = 2'd0,
      MEM_ST_REQ  = 2'd1,
      MEM_ST_DONE = 2'd2
   } mem_state_t;

   typedef logic [BE_W-1:0]   byte_en_bus_t;
   typedef logic [ADDR_W-1:0] word_addr_bus_t;

   // Little-endian byte k of a word, sign-extended to a full word.
   function automatic logic [WORD_W-1:0] extract_byte(input logic [WORD_W-1:0] word,
                                                      input logic [1:0] k);
      logic [7:0] b;
      b = word[8*k +: 8];
      return {{(WORD_W-8){b[7]}}, b};
   endfunction

endpackage

// File: rtl/yutorina_mem_ctrl.sv
// Bus master for the MEM stage: access decode, alignment check, req/ack FSM,
// bus output registers, byte lane select/replicate and the busy signal.
module yutorina_mem_ctrl
   import yutorina_mem_stage_pkg::*;
(
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 stall,
   input  logic                 flush,
   input  logic                 ex_en_,
   input  mem_op_t              ex_mem_op,
   input  exp_code_t            ex_exp_code,
   input  logic [WORD_W-1:0]    ex_w_data,
   input  logic [WORD_W-1:0]    ex_out,
   input  logic [WORD_W-1:0]    bus_rd_data,
   input  logic                 bus_ack_,
   output logic                 busy,
   output logic                 complete,
   output logic                 discard,
   output logic                 is_idle,
   output logic                 aligned_access,
   output logic                 miss_align,
   output logic                 is_load,
   output logic                 is_store,
   output logic [WORD_W-1:0]    load_data,
   output logic                 bus_req_,
   output logic                 bus_rw,
   output word_addr_bus_t       bus_addr,
   output byte_en_bus_t         bus_be,
   output logic [WORD_W-1:0]    bus_wr_data
);

   mem_state_t        state;
   mem_state_t        next_state;
   logic [WORD_W-1:0] rd_latch;
   logic [WORD_W-1:0] rd_word;
   logic              flushed;
   logic              access;
   logic              word_op;
   logic              ack;
   logic              issue;

   // Decode the EX instruction, derive handshake events and select load data.
   always_comb begin
      access         = (ex_en_ == ENABLE_) && (ex_mem_op != MEM_NONE) &&
                       (ex_exp_code == EXP_NONE) && !flush;
      word_op        = (ex_mem_op == MEM_LDW) || (ex_mem_op == MEM_STW);
      is_load        = (ex_mem_op == MEM_LDW) || (ex_mem_op == MEM_LDB);
      is_store       = (ex_mem_op == MEM_STW) || (ex_mem_op == MEM_STB);
      miss_align     = access && word_op && (ex_out[1:0] != 2'b00);
      aligned_access = access && !miss_align;
      is_idle        = (state == MEM_ST_IDLE);
      issue          = is_idle && aligned_access && !stall;
      ack            = (state == MEM_ST_REQ) && (bus_ack_ == ENABLE_);
      busy           = (is_idle && aligned_access) || !is_idle;
      complete       = (ack && !stall) || ((state == MEM_ST_DONE) && !stall);
      discard        = flush || flushed;
      rd_word        = (state == MEM_ST_REQ) ? bus_rd_data : rd_latch;
      load_data      = (ex_mem_op == MEM_LDB) ? extract_byte(rd_word, ex_out[1:0]) : rd_word;
   end

   // Next-state logic: issue from IDLE, wait for ack in REQ, park in DONE while stalled.
   always_comb begin
      next_state = state;
      case (state)
         MEM_ST_IDLE: if (issue)  next_state = MEM_ST_REQ;
         MEM_ST_REQ:  if (ack)    next_state = stall ? MEM_ST_DONE : MEM_ST_IDLE;
         MEM_ST_DONE: if (!stall) next_state = MEM_ST_IDLE;
         default:                 next_state = MEM_ST_IDLE;
      endcase
   end

   // State register.
   always_ff @(posedge clk) begin
      if (rst) state <= MEM_ST_IDLE;
      else     state <= next_state;
   end

   // Bus registers are loaded at issue and held until the next issue; a flush seen while
   // the access is outstanding is remembered so the eventual result can be dropped.
   always_ff @(posedge clk) begin
      if (rst) begin
         bus_req_    <= DISABLE_;
         bus_rw      <= 1'b0;
         bus_addr    <= '0;
         bus_be      <= '0;
         bus_wr_data <= '0;
         rd_latch    <= '0;
         flushed     <= 1'b0;
      end else if (issue) begin
         bus_req_    <= ENABLE_;
         bus_rw      <= is_load ? BUS_READ : BUS_WRITE;
         bus_addr    <= ex_out[WORD_W-1:2];
         bus_be      <= word_op ? {BE_W{1'b1}} : (BE_W'(1) << ex_out[1:0]);
         bus_wr_data <= (ex_mem_op == MEM_STB) ? {4{ex_w_data[7:0]}} : ex_w_data;
         flushed     <= 1'b0;
      end else begin
         if (ack) begin
            bus_req_ <= DISABLE_;
            rd_latch <= bus_rd_data;
         end
         if (!is_idle && flush) flushed <= 1'b1;
      end
   end

endmodule

// File: rtl/yutorina_mem_stage.sv
// MEM pipeline stage: wraps the bus master and owns the MEM/WB output registers,
// applying stall/flush gating and the misalignment exception.
module yutorina_mem_stage
   import yutorina_mem_stage_pkg::*;
(
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   stall,
   input  logic                   flush,
   input  logic                   ex_en_,
   input  logic [GPR_ADDR_W-1:0]  ex_w_addr,
   input  logic [WORD_W-1:0]      ex_w_data,
   input  logic                   ex_gpr_we_,
   input  exp_code_t              ex_exp_code,
   input  mem_op_t                ex_mem_op,
   input  ctrl_op_t               ex_ctrl_op,
   input  logic [WORD_W-1:0]      ex_out,
   output logic                   mem_en_,
   output logic [GPR_ADDR_W-1:0]  mem_w_addr,
   output logic                   mem_gpr_we_,
   output exp_code_t              mem_exp_code,
   output ctrl_op_t               mem_ctrl_op,
   output logic [WORD_W-1:0]      mem_out,
   output logic                   busy,
   output logic                   bus_req_,
   output logic                   bus_rw,
   output word_addr_bus_t         bus_addr,
   output byte_en_bus_t           bus_be,
   output logic [WORD_W-1:0]      bus_wr_data,
   input  logic [WORD_W-1:0]      bus_rd_data,
   input  logic                   bus_ack_
);

   logic              complete;
   logic              discard;
   logic              is_idle;
   logic              aligned_access;
   logic              miss_align;
   logic              is_load;
   logic              is_store;
   logic [WORD_W-1:0] load_data;

   yutorina_mem_ctrl u_ctrl (
      .clk            (clk),
      .rst            (rst),
      .stall          (stall),
      .flush          (flush),
      .ex_en_         (ex_en_),
      .ex_mem_op      (ex_mem_op),
      .ex_exp_code    (ex_exp_code),
      .ex_w_data      (ex_w_data),
      .ex_out         (ex_out),
      .bus_rd_data    (bus_rd_data),
      .bus_ack_       (bus_ack_),
      .busy           (busy),
      .complete       (complete),
      .discard        (discard),
      .is_idle        (is_idle),
      .aligned_access (aligned_access),
      .miss_align     (miss_align),
      .is_load        (is_load),
      .is_store       (is_store),
      .load_data      (load_data),
      .bus_req_       (bus_req_),
      .bus_rw         (bus_rw),
      .bus_addr       (bus_addr),
      .bus_be         (bus_be),
      .bus_wr_data    (bus_wr_data)
   );

   // Output registers: bus completions write the access result, otherwise IDLE passes
   // the EX instruction through in one cycle; stalls and outstanding accesses hold.
   always_ff @(posedge clk) begin
      if (rst) begin
         mem_en_      <= DISABLE_;
         mem_w_addr   <= '0;
         mem_gpr_we_  <= DISABLE_;
         mem_exp_code <= EXP_NONE;
         mem_ctrl_op  <= CTRL_NONE;
         mem_out      <= '0;
      end else if (complete) begin
         mem_en_     <= discard ? DISABLE_ : ENABLE_;
         mem_gpr_we_ <= (discard || is_store) ? DISABLE_ : ex_gpr_we_;
         if (!discard) begin
            mem_w_addr   <= ex_w_addr;
            mem_exp_code <= ex_exp_code;
            mem_ctrl_op  <= ex_ctrl_op;
            mem_out      <= is_load ? load_data : ex_out;
         end
      end else if (is_idle && !stall) begin
         if ((ex_en_ == DISABLE_) || flush || aligned_access) begin
            mem_en_     <= DISABLE_;
            mem_gpr_we_ <= DISABLE_;
         end else begin
            mem_en_      <= ENABLE_;
            mem_w_addr   <= ex_w_addr;
            mem_ctrl_op  <= ex_ctrl_op;
            mem_out      <= ex_out;
            mem_exp_code <= miss_align ? EXP_MISS_ALIGN : ex_exp_code;
            mem_gpr_we_  <= miss_align ? DISABLE_ : ex_gpr_we_;
         end
      end
   end

endmodule

// File: tb/tb_yutorina_mem_stage.sv
// Testbench for the MEM stage: directed scenarios plus a randomized instruction stream
// checked against a behavioural model of loads, stores and pass-through ops.
module tb_yutorina_mem_stage;
   import yutorina_mem_stage_pkg::*;

   logic                  clk = 1'b0;
   logic                  rst;
   logic                  stall;
   logic                  flush;
   logic                  ex_en_;
   logic [GPR_ADDR_W-1:0] ex_w_addr;
   logic [WORD_W-1:0]     ex_w_data;
   logic                  ex_gpr_we_;
   exp_code_t             ex_exp_code;
   mem_op_t               ex_mem_op;
   ctrl_op_t              ex_ctrl_op;
   logic [WORD_W-1:0]     ex_out;
   logic                  mem_en_;
   logic [GPR_ADDR_W-1:0] mem_w_addr;
   logic                  mem_gpr_we_;
   exp_code_t             mem_exp_code;
   ctrl_op_t              mem_ctrl_op;
   logic [WORD_W-1:0]     mem_out;
   logic                  busy;
   logic                  bus_req_;
   logic                  bus_rw;
   logic [ADDR_W-1:0]     bus_addr;
   logic [BE_W-1:0]       bus_be;
   logic [WORD_W-1:0]     bus_wr_data;
   logic [WORD_W-1:0]     bus_rd_data;
   logic                  bus_ack_;

   int checks = 0;
   int errors = 0;

   yutorina_mem_stage dut (
      .clk(clk), .rst(rst), .stall(stall), .flush(flush),
      .ex_en_(ex_en_), .ex_w_addr(ex_w_addr), .ex_w_data(ex_w_data),
      .ex_gpr_we_(ex_gpr_we_), .ex_exp_code(ex_exp_code), .ex_mem_op(ex_mem_op),
      .ex_ctrl_op(ex_ctrl_op), .ex_out(ex_out),
      .mem_en_(mem_en_), .mem_w_addr(mem_w_addr), .mem_gpr_we_(mem_gpr_we_),
      .mem_exp_code(mem_exp_code), .mem_ctrl_op(mem_ctrl_op), .mem_out(mem_out),
      .busy(busy), .bus_req_(bus_req_), .bus_rw(bus_rw), .bus_addr(bus_addr),
      .bus_be(bus_be), .bus_wr_data(bus_wr_data), .bus_rd_data(bus_rd_data),
      .bus_ack_(bus_ack_)
   );

   always #5 clk = ~clk;

   // Advance to just after the next rising edge.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic set_ex(input logic en_, input mem_op_t op, input logic [31:0] out,
                         input logic [31:0] wdata, input logic [4:0] waddr,
                         input logic gwe_, input exp_code_t exp, input ctrl_op_t ctrl);
      ex_en_      = en_;
      ex_mem_op   = op;
      ex_out      = out;
      ex_w_data   = wdata;
      ex_w_addr   = waddr;
      ex_gpr_we_  = gwe_;
      ex_exp_code = exp;
      ex_ctrl_op  = ctrl;
      #1;
   endtask

   task automatic set_idle();
      set_ex(DISABLE_, MEM_NONE, 32'h0, 32'h0, 5'd0, DISABLE_, EXP_NONE, CTRL_NONE);
   endtask

   task automatic test_reset();
      rst = 1'b1; stall = 1'b0; flush = 1'b0; bus_ack_ = 1'b1; bus_rd_data = '0;
      set_idle();
      step(); step();
      checks++; if (mem_en_ !== 1'b1) begin errors++; $display("[TB] FAIL rst_mem_en got %b want 1", mem_en_); end
      checks++; if (mem_gpr_we_ !== 1'b1) begin errors++; $display("[TB] FAIL rst_gpr_we got %b want 1", mem_gpr_we_); end
      checks++; if (bus_req_ !== 1'b1) begin errors++; $display("[TB] FAIL rst_bus_req got %b want 1", bus_req_); end
      checks++; if (mem_exp_code !== EXP_NONE || mem_ctrl_op !== CTRL_NONE) begin errors++; $display("[TB] FAIL rst_codes got %0d/%0d want 0/0", mem_exp_code, mem_ctrl_op); end
      checks++; if (mem_out !== 32'h0 || bus_addr !== 30'h0 || bus_be !== 4'h0 || bus_wr_data !== 32'h0 || bus_rw !== 1'b0) begin
         errors++; $display("[TB] FAIL rst_data got out=%h addr=%h be=%h wd=%h rw=%b want zeros", mem_out, bus_addr, bus_be, bus_wr_data, bus_rw); end
      checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL rst_busy got %b want 0", busy); end
      rst = 1'b0;
   endtask

   task automatic test_alu();
      set_ex(ENABLE_, MEM_NONE, 32'h1234, 32'h0, 5'd3, ENABLE_, EXP_NONE, CTRL_WRCR);
      checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL alu_busy got %b want 0", busy); end
      step();
      checks++; if (mem_out !== 32'h1234) begin errors++; $display("[TB] FAIL alu_out got %h want 00001234", mem_out); end
      checks++; if (mem_en_ !== 1'b0 || mem_gpr_we_ !== 1'b0 || mem_w_addr !== 5'd3 || mem_ctrl_op !== CTRL_WRCR) begin
         errors++; $display("[TB] FAIL alu_fields got en=%b we=%b wa=%0d ctrl=%0d want 0 0 3 1", mem_en_, mem_gpr_we_, mem_w_addr, mem_ctrl_op); end
      set_idle();
   endtask

   task automatic test_ldw();
      int busy_cycles = 0;
      set_ex(ENABLE_, MEM_LDW, 32'h100, 32'h0, 5'd7, ENABLE_, EXP_NONE, CTRL_NONE);
      if (busy) busy_cycles++;
      step();
      if (busy) busy_cycles++;
      checks++; if (bus_req_ !== 1'b0 || bus_addr !== 30'h40 || bus_be !== 4'hF || bus_rw !== BUS_READ) begin
         errors++; $display("[TB] FAIL ldw_bus got req=%b addr=%h be=%h rw=%b want 0 40 f 1", bus_req_, bus_addr, bus_be, bus_rw); end
      checks++; if (mem_en_ !== 1'b1) begin errors++; $display("[TB] FAIL ldw_bubble got %b want 1", mem_en_); end
      bus_ack_ = 1'b0; bus_rd_data = 32'hDEADBEEF;
      step();
      bus_ack_ = 1'b1;
      set_idle();
      if (busy) busy_cycles++;
      checks++; if (busy_cycles != 2) begin errors++; $display("[TB] FAIL ldw_busy_cycles got %0d want 2", busy_cycles); end
      checks++; if (mem_out !== 32'hDEADBEEF || mem_en_ !== 1'b0 || mem_gpr_we_ !== 1'b0 || mem_w_addr !== 5'd7) begin
         errors++; $display("[TB] FAIL ldw_result got out=%h en=%b we=%b wa=%0d want deadbeef 0 0 7", mem_out, mem_en_, mem_gpr_we_, mem_w_addr); end
      checks++; if (bus_req_ !== 1'b1) begin errors++; $display("[TB] FAIL ldw_req_drop got %b want 1", bus_req_); end
   endtask

   task automatic test_stb_wait();
      set_ex(ENABLE_, MEM_STB, 32'h103, 32'h5A, 5'd2, ENABLE_, EXP_NONE, CTRL_NONE);
      step();
      for (int i = 0; i < 3; i++) begin
         checks++; if (bus_req_ !== 1'b0 || bus_be !== 4'b1000 || bus_wr_data !== 32'h5A5A5A5A || bus_addr !== 30'h40 || bus_rw !== BUS_WRITE || busy !== 1'b1) begin
            errors++; $display("[TB] FAIL stb_hold%0d got req=%b be=%b wd=%h addr=%h rw=%b busy=%b want 0 1000 5a5a5a5a 40 0 1", i, bus_req_, bus_be, bus_wr_data, bus_addr, bus_rw, busy); end
         step();
      end
      bus_ack_ = 1'b0;
      step();
      bus_ack_ = 1'b1;
      set_idle();
      checks++; if (mem_gpr_we_ !== 1'b1 || mem_en_ !== 1'b0 || mem_out !== 32'h103 || bus_req_ !== 1'b1) begin
         errors++; $display("[TB] FAIL stb_result got we=%b en=%b out=%h req=%b want 1 0 103 1", mem_gpr_we_, mem_en_, mem_out, bus_req_); end
   endtask

   task automatic test_ldb();
      set_ex(ENABLE_, MEM_LDB, 32'h102, 32'h0, 5'd9, ENABLE_, EXP_NONE, CTRL_NONE);
      step();
      checks++; if (bus_be !== 4'b0100) begin errors++; $display("[TB] FAIL ldb_be got %b want 0100", bus_be); end
      bus_ack_ = 1'b0; bus_rd_data = 32'h00800000;
      step();
      bus_ack_ = 1'b1;
      set_idle();
      checks++; if (mem_out !== 32'hFFFFFF80) begin errors++; $display("[TB] FAIL ldb_sext got %h want ffffff80", mem_out); end
   endtask

   task automatic test_misalign();
      set_ex(ENABLE_, MEM_LDW, 32'h102, 32'h0, 5'd5, ENABLE_, EXP_NONE, CTRL_NONE);
      checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL mis_busy got %b want 0", busy); end
      step();
      checks++; if (bus_req_ !== 1'b1 || mem_exp_code !== EXP_MISS_ALIGN || mem_gpr_we_ !== 1'b1 || mem_en_ !== 1'b0 || mem_out !== 32'h102) begin
         errors++; $display("[TB] FAIL mis_result got req=%b exp=%0d we=%b en=%b out=%h want 1 4 1 0 102", bus_req_, mem_exp_code, mem_gpr_we_, mem_en_, mem_out); end
      set_idle();
      step();
   endtask

   task automatic test_stall_done();
      set_ex(ENABLE_, MEM_LDW, 32'h200, 32'h0, 5'd11, ENABLE_, EXP_NONE, CTRL_NONE);
      step();
      stall = 1'b1; bus_ack_ = 1'b0; bus_rd_data = 32'h13572468;
      step();
      bus_ack_ = 1'b1;
      for (int i = 0; i < 2; i++) begin
         checks++; if (bus_req_ !== 1'b1 || busy !== 1'b1 || mem_en_ !== 1'b1) begin
            errors++; $display("[TB] FAIL done_hold%0d got req=%b busy=%b en=%b want 1 1 1", i, bus_req_, busy, mem_en_); end
         bus_rd_data = 32'hFFFFFFFF;
         step();
      end
      stall = 1'b0; #1;
      checks++; if (busy !== 1'b1) begin errors++; $display("[TB] FAIL done_busy got %b want 1", busy); end
      step();
      set_idle();
      checks++; if (mem_out !== 32'h13572468 || mem_en_ !== 1'b0 || busy !== 1'b0) begin
         errors++; $display("[TB] FAIL done_result got out=%h en=%b busy=%b want 13572468 0 0", mem_out, mem_en_, busy); end
   endtask

   task automatic test_flush_req();
      logic [31:0] prev;
      prev = mem_out;
      set_ex(ENABLE_, MEM_LDW, 32'h300, 32'h0, 5'd4, ENABLE_, EXP_NONE, CTRL_NONE);
      step();
      flush = 1'b1; #1;
      step();
      flush = 1'b0;
      checks++; if (bus_req_ !== 1'b0 || busy !== 1'b1) begin errors++; $display("[TB] FAIL flush_cont got req=%b busy=%b want 0 1", bus_req_, busy); end
      bus_ack_ = 1'b0; bus_rd_data = 32'h0BADF00D;
      step();
      bus_ack_ = 1'b1;
      set_idle();
      checks++; if (mem_en_ !== 1'b1 || mem_gpr_we_ !== 1'b1 || bus_req_ !== 1'b1 || mem_out !== prev) begin
         errors++; $display("[TB] FAIL flush_result got en=%b we=%b req=%b out=%h want 1 1 1 %h", mem_en_, mem_gpr_we_, bus_req_, mem_out, prev); end
   endtask

   task automatic test_stall_flush_idle();
      set_ex(ENABLE_, MEM_NONE, 32'h55, 32'h0, 5'd1, ENABLE_, EXP_NONE, CTRL_NONE);
      step();
      stall = 1'b1;
      set_ex(ENABLE_, MEM_NONE, 32'h66, 32'h0, 5'd1, ENABLE_, EXP_NONE, CTRL_NONE);
      step();
      checks++; if (mem_out !== 32'h55 || mem_en_ !== 1'b0) begin errors++; $display("[TB] FAIL stall_hold got out=%h en=%b want 55 0", mem_out, mem_en_); end
      set_ex(ENABLE_, MEM_LDW, 32'h400, 32'h0, 5'd1, ENABLE_, EXP_NONE, CTRL_NONE);
      checks++; if (busy !== 1'b1) begin errors++; $display("[TB] FAIL stall_busy got %b want 1", busy); end
      step();
      checks++; if (bus_req_ !== 1'b1) begin errors++; $display("[TB] FAIL stall_noissue got %b want 1", bus_req_); end
      stall = 1'b0; flush = 1'b1; #1;
      checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL flush_idle_busy got %b want 0", busy); end
      step();
      flush = 1'b0;
      checks++; if (mem_en_ !== 1'b1 || bus_req_ !== 1'b1) begin errors++; $display("[TB] FAIL flush_idle got en=%b req=%b want 1 1", mem_en_, bus_req_); end
      set_ex(DISABLE_, MEM_NONE, 32'h77, 32'h0, 5'd1, ENABLE_, EXP_NONE, CTRL_NONE);
      step();
      checks++; if (mem_en_ !== 1'b1 || mem_gpr_we_ !== 1'b1 || mem_out !== 32'h55) begin
         errors++; $display("[TB] FAIL exdis got en=%b we=%b out=%h want 1 1 55", mem_en_, mem_gpr_we_, mem_out); end
   endtask

   task automatic test_rst_req();
      set_ex(ENABLE_, MEM_LDW, 32'h500, 32'h0, 5'd6, ENABLE_, EXP_NONE, CTRL_NONE);
      step();
      checks++; if (bus_req_ !== 1'b0) begin errors++; $display("[TB] FAIL rstreq_pre got %b want 0", bus_req_); end
      rst = 1'b1;
      set_idle();
      step();
      rst = 1'b0;
      checks++; if (bus_req_ !== 1'b1 || bus_addr !== 30'h0 || busy !== 1'b0) begin
         errors++; $display("[TB] FAIL rstreq got req=%b addr=%h busy=%b want 1 0 0", bus_req_, bus_addr, busy); end
      bus_ack_ = 1'b0; bus_rd_data = 32'h12345678;
      step();
      bus_ack_ = 1'b1;
      checks++; if (mem_en_ !== 1'b1 || busy !== 1'b0 || mem_out === 32'h12345678) begin
         errors++; $display("[TB] FAIL stray_ack got en=%b busy=%b out=%h want 1 0 not-12345678", mem_en_, busy, mem_out); end
   endtask

   // Randomized back-to-back instruction stream against a behavioural model.
   task automatic test_random();
      for (int n = 0; n < 60; n++) begin
         mem_op_t     op;
         exp_code_t   exp;
         logic [31:0] addr, data, rd, want_out, want_wd, b;
         logic [4:0]  wa;
         logic        gwe, acc, mis, load, word;
         logic [3:0]  want_be;
         int          k, waits;
         op    = mem_op_t'(3'($urandom_range(0, 4)));
         exp   = ($urandom_range(0, 5) == 0) ? EXP_OVERFLOW : EXP_NONE;
         addr  = $urandom;
         if ($urandom_range(0, 1) == 1) addr[1:0] = 2'b00;
         data  = $urandom;
         rd    = $urandom;
         wa    = 5'($urandom_range(0, 31));
         gwe   = 1'($urandom_range(0, 1));
         waits = $urandom_range(0, 3);
         k     = int'(addr[1:0]);
         word  = (op == MEM_LDW) || (op == MEM_STW);
         load  = (op == MEM_LDW) || (op == MEM_LDB);
         acc   = (op != MEM_NONE) && (exp == EXP_NONE);
         mis   = acc && word && (addr % 4 != 0);
         set_ex(ENABLE_, op, addr, data, wa, gwe, exp, CTRL_NONE);
         checks++; if (busy !== (acc && !mis)) begin errors++; $display("[TB] FAIL rnd%0d_busy got %b want %b", n, busy, acc && !mis); end
         if (!acc || mis) begin
            step();
            checks++; if (mem_en_ !== 1'b0 || mem_out !== addr || mem_w_addr !== wa || bus_req_ !== 1'b1 ||
                          mem_exp_code !== (mis ? EXP_MISS_ALIGN : exp) || mem_gpr_we_ !== (mis ? 1'b1 : gwe)) begin
               errors++; $display("[TB] FAIL rnd%0d_pass got en=%b out=%h wa=%0d req=%b exp=%0d we=%b want op=%0d out=%h mis=%b", n, mem_en_, mem_out, mem_w_addr, bus_req_, mem_exp_code, mem_gpr_we_, op, addr, mis); end
         end else begin
            want_be = word ? 4'hF : 4'(1 << k);
            want_wd = (op == MEM_STB) ? (data & 32'hFF) * 32'h01010101 : data;
            b       = (rd >> (8 * k)) & 32'hFF;
            if (op == MEM_LDW)      want_out = rd;
            else if (op == MEM_LDB) want_out = (b >= 128) ? (b | 32'hFFFFFF00) : b;
            else                    want_out = addr;
            step();
            for (int w = 0; w <= waits; w++) begin
               checks++; if (bus_req_ !== 1'b0 || bus_addr !== addr[31:2] || bus_be !== want_be || bus_wr_data !== want_wd || bus_rw !== load) begin
                  errors++; $display("[TB] FAIL rnd%0d_bus got req=%b addr=%h be=%b wd=%h rw=%b want 0 %h %b %h %b", n, bus_req_, bus_addr, bus_be, bus_wr_data, bus_rw, addr[31:2], want_be, want_wd, load); end
               if (w == waits) begin bus_ack_ = 1'b0; bus_rd_data = rd; end
               else bus_rd_data = $urandom;
               step();
            end
            bus_ack_ = 1'b1;
            checks++; if (mem_en_ !== 1'b0 || mem_out !== want_out || mem_w_addr !== wa || bus_req_ !== 1'b1 || mem_gpr_we_ !== (load ? gwe : 1'b1)) begin
               errors++; $display("[TB] FAIL rnd%0d_mem got en=%b out=%h wa=%0d req=%b we=%b want 0 %h %0d 1 %b", n, mem_en_, mem_out, mem_w_addr, bus_req_, mem_gpr_we_, want_out, wa, load ? gwe : 1'b1); end
         end
      end
      set_idle();
      step();
   endtask

   initial begin
      test_reset();
      test_alu();
      test_ldw();
      test_stb_wait();
      test_ldb();
      test_misalign();
      test_stall_done();
      test_flush_req();
      test_stall_flush_idle();
      test_rst_req();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #500000;
      $display("[TB] FAIL watchdog timeout");
      $fatal(1, "[TB] simulation did not terminate");
   end

endmodule
